// File: rtl/motor_drive_hbridge.sv
// ============================================================================
// Module  : motor_drive_hbridge
// Purpose : N-channel signed-command to H-bridge PWM driver with slew limiting,
//           dead-time insertion on reversal and per-channel active brake.
// Revision: 1.0
// ============================================================================
`default_nettype none

module motor_drive_hbridge #(
    parameter int NCH       = 2,
    parameter int CMD_W     = 11,
    parameter int DEAD_CYC  = 16,
    parameter int SLEW_STEP = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [NCH*CMD_W-1:0] cmd,
    input  logic [NCH-1:0]       brake,
    output logic [NCH-1:0]       fwd,
    output logic [NCH-1:0]       rev,
    output logic                 prd_stb
);

    localparam int PWM_W = CMD_W - 1;
    localparam int DW    = (DEAD_CYC < 2) ? 1 : $clog2(DEAD_CYC);
    localparam logic [PWM_W-1:0]        C_CNT_PRE = {{(PWM_W-1){1'b1}}, 1'b0};
    localparam logic [DW-1:0]           C_DEAD_LD = DW'(DEAD_CYC - 1);
    localparam logic signed [CMD_W:0]   C_STEP_W  = (CMD_W+1)'(SLEW_STEP);
    localparam logic signed [CMD_W-1:0] C_STEP    = CMD_W'(SLEW_STEP);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_FWD   = 3'd1,
        S_REV   = 3'd2,
        S_DEAD  = 3'd3,
        S_BRAKE = 3'd4
    } state_t;

    logic [PWM_W-1:0] cnt_q;
    logic             prd_q;

    // The strobe is registered one count early so it is high while cnt_q is at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            prd_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            prd_q <= (cnt_q == C_CNT_PRE);
        end
    end

    assign prd_stb = prd_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic signed [CMD_W-1:0] cmd_q;
        logic signed [CMD_W-1:0] apl_q;
        logic signed [CMD_W-1:0] apl_d;
        logic signed [CMD_W:0]   diff;
        logic        [CMD_W-1:0] neg;
        logic        [PWM_W-1:0] mag;
        logic                    pwm;
        logic                    apl_pos;
        logic                    apl_neg;
        state_t                  state_q;
        state_t                  lat_q;
        logic        [DW-1:0]    dead_q;
        logic                    fwd_q;
        logic                    rev_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cmd_q <= '0;
                apl_q <= '0;
            end else begin
                cmd_q <= cmd[i*CMD_W +: CMD_W];
                apl_q <= apl_d;
            end
        end

        always_comb begin
            diff  = {cmd_q[CMD_W-1], cmd_q} - {apl_q[CMD_W-1], apl_q};
            apl_d = apl_q;
            if (!en) begin
                apl_d = '0;
            end else if (prd_q) begin
                if ((SLEW_STEP == 0) || ((diff <= C_STEP_W) && (diff >= -C_STEP_W))) begin
                    apl_d = cmd_q;
                end else if (diff > 0) begin
                    apl_d = apl_q + C_STEP;
                end else begin
                    apl_d = apl_q - C_STEP;
                end
            end
        end

        // Most-negative command has no positive twin; it saturates to full scale.
        assign neg     = '0 - apl_q;
        assign mag     = apl_q[CMD_W-1] ? (neg[CMD_W-1] ? '1 : neg[PWM_W-1:0])
                                        : apl_q[PWM_W-1:0];
        assign pwm     = (cnt_q < mag);
        assign apl_neg = apl_q[CMD_W-1];
        assign apl_pos = !apl_q[CMD_W-1] && (apl_q != '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_OFF;
                lat_q   <= S_OFF;
                dead_q  <= '0;
                fwd_q   <= 1'b0;
                rev_q   <= 1'b0;
            end else if (!en) begin
                state_q <= S_OFF;
                dead_q  <= '0;
                fwd_q   <= 1'b0;
                rev_q   <= 1'b0;
            end else begin
                fwd_q <= 1'b0;
                rev_q <= 1'b0;
                case (state_q)
                    S_OFF: begin
                        if (brake[i]) begin
                            state_q <= S_BRAKE;
                            fwd_q   <= 1'b1;
                            rev_q   <= 1'b1;
                        end else if (apl_pos) begin
                            state_q <= S_FWD;
                            fwd_q   <= pwm;
                        end else if (apl_neg) begin
                            state_q <= S_REV;
                            rev_q   <= pwm;
                        end
                    end
                    S_FWD: begin
                        if (brake[i] || apl_neg) begin
                            state_q <= S_DEAD;
                            lat_q   <= brake[i] ? S_BRAKE : S_REV;
                            dead_q  <= C_DEAD_LD;
                        end else if (!apl_pos) begin
                            state_q <= S_OFF;
                        end else begin
                            fwd_q <= pwm;
                        end
                    end
                    S_REV: begin
                        if (brake[i] || apl_pos) begin
                            state_q <= S_DEAD;
                            lat_q   <= brake[i] ? S_BRAKE : S_FWD;
                            dead_q  <= C_DEAD_LD;
                        end else if (!apl_neg) begin
                            state_q <= S_OFF;
                        end else begin
                            rev_q <= pwm;
                        end
                    end
                    S_DEAD: begin
                        // Drive is qualified by the present sign so a stale target never pulses the wrong leg.
                        if (dead_q == '0) begin
                            state_q <= lat_q;
                            fwd_q   <= (lat_q == S_BRAKE) || ((lat_q == S_FWD) && apl_pos && pwm);
                            rev_q   <= (lat_q == S_BRAKE) || ((lat_q == S_REV) && apl_neg && pwm);
                        end else begin
                            dead_q <= dead_q - 1'b1;
                        end
                    end
                    S_BRAKE: begin
                        if (!brake[i]) begin
                            state_q <= S_OFF;
                        end else begin
                            fwd_q <= 1'b1;
                            rev_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_OFF;
                    end
                endcase
            end
        end

        assign fwd[i] = fwd_q;
        assign rev[i] = rev_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_motor_drive_hbridge.sv
// ============================================================================
// Module  : tb_motor_drive_hbridge
// Purpose : Directed bench for motor_drive_hbridge; two instances, slew off/on.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_motor_drive_hbridge;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [21:0] cmd_a;
    logic [21:0] cmd_b;
    logic [1:0]  brake_a;
    logic [1:0]  brake_b;
    logic [1:0]  fwd_a;
    logic [1:0]  rev_a;
    logic [1:0]  fwd_b;
    logic [1:0]  rev_b;
    logic        prd_a;
    logic        prd_b;

    int total = 0;
    int bad   = 0;
    int nf_a[2];
    int nr_a[2];
    int nf_b[2];
    int nr_b[2];
    int first_rev_a0;
    int first_both_a1;
    int ovl   = 0;
    bit ovl_en = 1'b0;
    int n_sync;

    motor_drive_hbridge #(.NCH(2), .CMD_W(11), .DEAD_CYC(16), .SLEW_STEP(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd_a), .brake(brake_a),
        .fwd(fwd_a), .rev(rev_a), .prd_stb(prd_a)
    );

    motor_drive_hbridge #(.NCH(2), .CMD_W(11), .DEAD_CYC(16), .SLEW_STEP(32)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .cmd(cmd_b), .brake(brake_b),
        .fwd(fwd_b), .rev(rev_b), .prd_stb(prd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ovl_en && fwd_a[0] && rev_a[0]) ovl++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge where the period strobe is high.
    task automatic sync(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!prd_a && n < 3000);
        check("sync_stb", int'(prd_a), 1);
    endtask

    // Count pin activity over one full period; sample index equals counter value.
    task automatic measure();
        for (int k = 0; k < 2; k++) begin
            nf_a[k] = 0; nr_a[k] = 0; nf_b[k] = 0; nr_b[k] = 0;
        end
        first_rev_a0  = -1;
        first_both_a1 = -1;
        for (int c = 0; c < 1024; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                nf_a[k] += int'(fwd_a[k]);
                nr_a[k] += int'(rev_a[k]);
                nf_b[k] += int'(fwd_b[k]);
                nr_b[k] += int'(rev_b[k]);
            end
            if (rev_a[0] && first_rev_a0 < 0) first_rev_a0 = c;
            if (fwd_a[1] && rev_a[1] && first_both_a1 < 0) first_both_a1 = c;
        end
        check("period_end_stb", int'(prd_a), 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        cmd_a   = '0;
        cmd_b   = '0;
        brake_a = '0;
        brake_b = '0;
        repeat (3) @(negedge clk);
        check("rst_pins_a", int'({fwd_a, rev_a}), 0);
        check("rst_pins_b", int'({fwd_b, rev_b}), 0);
        check("rst_prd_stb", int'(prd_a), 0);

        // Forward at 256/1024
        rst_n        = 1'b1;
        en           = 1'b1;
        cmd_a[10:0]  = 11'sd256;
        sync(n_sync);
        check("rst_to_first_stb", n_sync, 1023);
        measure();
        check("t1_fwd0", nf_a[0], 256);
        check("t1_rev0", nr_a[0], 0);
        check("t1_fwd1_idle", nf_a[1], 0);
        check("t1_slew_idle", nf_b[0], 0);

        // Full-scale negative saturates
        cmd_a[10:0] = 11'h400;
        sync(n_sync);
        sync(n_sync);
        measure();
        check("t2_rev0", nr_a[0], 1023);
        check("t2_fwd0", nf_a[0], 0);

        // Reversal +300 -> -300 with dead time
        cmd_a[10:0] = 11'sd300;
        sync(n_sync);
        sync(n_sync);
        measure();
        check("t3_fwd0_300", nf_a[0], 300);
        cmd_a[10:0] = -11'sd300;
        ovl_en = 1'b1;
        sync(n_sync);
        measure();
        check("t3_fwd0_after", nf_a[0], 0);
        check("t3_rev_first", first_rev_a0, 17);
        check("t3_rev0_partial", nr_a[0], 284);
        measure();
        check("t3_rev0_full", nr_a[0], 300);
        ovl_en = 1'b0;
        check("t3_overlap", ovl, 0);

        // Brake on channel 1 while forward
        cmd_a[21:11] = 11'sd200;
        sync(n_sync);
        measure();
        check("t5_fwd1_200", nf_a[1], 200);
        check("t5_rev0_pre", nr_a[0], 300);
        brake_a[1] = 1'b1;
        measure();
        check("t5_both_first", first_both_a1, 16);
        check("t5_fwd1_brake", nf_a[1], 1008);
        check("t5_rev1_brake", nr_a[1], 1008);
        check("t5_rev0_unaff", nr_a[0], 300);
        brake_a[1] = 1'b0;
        @(negedge clk);
        check("t5_release_pins", int'({fwd_a[1], rev_a[1]}), 0);
        sync(n_sync);
        measure();
        check("t5_fwd1_resume", nf_a[1], 200);
        check("t5_rev1_resume", nr_a[1], 0);

        // Slew-limited ramp 0 -> +100
        cmd_b[10:0] = 11'sd100;
        sync(n_sync);
        measure();
        check("t4_step32", nf_b[0], 32);
        check("t4_rev_b0", nr_b[0], 0);
        measure();
        check("t4_step64", nf_b[0], 64);
        measure();
        check("t4_step96", nf_b[0], 96);
        measure();
        check("t4_step100", nf_b[0], 100);

        // Enable drop mid-period and slew restart
        cmd_a[10:0] = 11'sd500;
        sync(n_sync);
        sync(n_sync);
        repeat (100) @(negedge clk);
        check("t6_fwd_a0_on", int'(fwd_a[0]), 1);
        check("t6_fwd_b0_on", int'(fwd_b[0]), 1);
        en = 1'b0;
        @(negedge clk);
        check("t6_en_off_a", int'({fwd_a, rev_a}), 0);
        check("t6_en_off_b", int'({fwd_b, rev_b}), 0);
        en = 1'b1;
        sync(n_sync);
        measure();
        check("t6_slew_restart", nf_b[0], 32);
        check("t6_noslew_500", nf_a[0], 500);

        // Asynchronous reset in the middle of a pulse
        repeat (5) @(negedge clk);
        check("t6_pulse_high", int'(fwd_a[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_rst_a", int'({fwd_a, rev_a}), 0);
        check("t6_async_rst_b", int'({fwd_b, rev_b}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        sync(n_sync);
        check("t6_rst_cnt_restart", n_sync, 1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
